// File: rtl/iter_branch_cmp_if.sv
// Request/response bundle for the iterative branch comparator.
// The master drives operands and function; the slave returns the branch decision.
interface iter_branch_cmp_if #(
  parameter int N = 32
);
  logic [N-1:0] vin_a;
  logic [N-1:0] vin_b;
  logic [2:0]   func;
  logic         in_valid;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic         vout;
  logic         illegal;

  modport master (
    output vin_a, vin_b, func, in_valid, out_ready,
    input  in_ready, out_valid, vout, illegal
  );

  modport slave (
    input  vin_a, vin_b, func, in_valid, out_ready,
    output in_ready, out_valid, vout, illegal
  );
endinterface

// File: rtl/iter_branch_cmp.sv
// RV32I branch resolver: scans W-bit slices MSB-first and stops at the first difference.
// Latency is j+1 cycles (S for equal operands, 1 for illegal funct3); the result is held until out_ready.
module iter_branch_cmp #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  iter_branch_cmp_if.slave bus
);

  localparam int S  = N / W;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] K_TOP   = KW'(S - 1);
  localparam logic [W-1:0]  MSB_BIT = W'(1) << (W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [2:0]    func_q, func_d;
  logic [KW-1:0] k_q, k_d;
  logic          vout_q, vout_d;
  logic          illegal_q, illegal_d;

  logic [W-1:0]  a_key;
  logic [W-1:0]  b_key;
  logic          signed_slice;
  logic          slice_eq;
  logic          slice_lt;

  function automatic logic resolve(input logic [2:0] f, input logic eq, input logic lt);
    case (f)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      k_q       <= '0;
      vout_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      func_q    <= func_d;
      k_q       <= k_d;
      vout_q    <= vout_d;
      illegal_q <= illegal_d;
    end
  end

  // Operands shift left each step, so the slice under test always sits at the top.
  // Flipping the sign bit turns the signed top-slice compare into an unsigned one.
  always_comb begin
    signed_slice = (k_q == K_TOP) && (func_q[2:1] == 2'b10);
    a_key        = a_q[N-1 -: W] ^ (signed_slice ? MSB_BIT : '0);
    b_key        = b_q[N-1 -: W] ^ (signed_slice ? MSB_BIT : '0);
    slice_eq     = (a_key == b_key);
    slice_lt     = (a_key < b_key);
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    func_d    = func_q;
    k_d       = k_q;
    vout_d    = vout_q;
    illegal_d = illegal_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d       = bus.vin_a;
          b_d       = bus.vin_b;
          func_d    = bus.func;
          k_d       = K_TOP;
          illegal_d = (bus.func[2:1] == 2'b01);
          state_d   = RUN;
        end
      end
      RUN: begin
        // An illegal request spends one cycle here so it reports with the same timing as a first-slice hit.
        if (illegal_q) begin
          vout_d  = 1'b0;
          state_d = DONE;
        end else if (!slice_eq) begin
          vout_d  = resolve(func_q, 1'b0, slice_lt);
          state_d = DONE;
        end else if (k_q == '0) begin
          vout_d  = resolve(func_q, 1'b1, 1'b0);
          state_d = DONE;
        end else begin
          k_d = k_q - 1'b1;
          a_d = a_q << W;
          b_d = b_q << W;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.vout      = vout_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_iter_branch_cmp.sv
// Self-checking bench for iter_branch_cmp: directed vector table, reset abort, input churn and random requests.
module tb_iter_branch_cmp;

  localparam int N = 32;
  localparam int W = 8;
  localparam int S = N / W;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  iter_branch_cmp_if #(.N(N)) bus ();

  iter_branch_cmp #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;
    int          hold;
    logic        ev;
    logic        ei;
    int          el;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: branch outcome from whole-operand arithmetic, latency from the highest differing bit.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                                output logic v, output logic il, output int lat);
    logic [31:0] x;
    int p;
    il = (f == 3'b010) || (f == 3'b011);
    x  = a ^ b;
    p  = -1;
    for (int i = 0; i < 32; i++) if (x[i]) p = i;
    if (il)         lat = 1;
    else if (p < 0) lat = S;
    else            lat = (31 - p) / W + 1;
    case (f)
      3'b000:  v = (a == b);
      3'b001:  v = (a != b);
      3'b100:  v = ($signed(a) < $signed(b));
      3'b101:  v = ($signed(a) >= $signed(b));
      3'b110:  v = (a < b);
      3'b111:  v = (a >= b);
      default: v = 1'b0;
    endcase
    if (il) v = 1'b0;
  endfunction

  task automatic scramble();
    bus.vin_a     = $urandom;
    bus.vin_b     = $urandom;
    bus.func      = 3'($urandom_range(0, 7));
    bus.in_valid  = 1'($urandom_range(0, 1));
    bus.out_ready = 1'($urandom_range(0, 1));
  endtask

  // Entered and left at a falling edge with the block idle.
  task automatic run_req(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f,
                         input int hold, input bit tog, input logic ev, input logic ei, input int el);
    int  n;
    int  lat;
    bit  got;
    n = 0;
    while (!bus.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("in_ready_wait", 32'(bus.in_ready), 32'd1);
      return;
    end
    bus.vin_a    = a;
    bus.vin_b    = b;
    bus.func     = f;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (tog) scramble();
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else if (tog) scramble();
    end
    chk("latency", 32'(lat), 32'(el));
    if (!got) return;
    chk("vout", 32'(bus.vout), 32'(ev));
    chk("illegal", 32'(bus.illegal), 32'(ei));
    for (int h = 0; h < hold; h++) begin
      if (tog) scramble();
      bus.out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_vld_vout_rdy", {29'd0, bus.out_valid, bus.vout, bus.in_ready}, {29'd0, 1'b1, ev, 1'b0});
    end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_vld_rdy", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
  endtask

  initial begin
    logic        ev;
    logic        ei;
    int          el;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  f;

    errors = 0;
    checks = 0;

    tbl[0]  = '{32'h12345678, 32'h12345678, 3'b000, 0, 1'b1, 1'b0, 4};
    tbl[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 0, 1'b1, 1'b0, 1};
    tbl[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 0, 1'b0, 1'b0, 1};
    tbl[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 0, 1'b1, 1'b0, 1};
    tbl[4]  = '{32'h00000100, 32'h00000200, 3'b001, 5, 1'b1, 1'b0, 3};
    tbl[5]  = '{32'hDEADBEEF, 32'hDEADBEEF, 3'b010, 0, 1'b0, 1'b1, 1};
    tbl[6]  = '{32'h00000000, 32'h00000000, 3'b101, 0, 1'b1, 1'b0, 4};
    tbl[7]  = '{32'h80000000, 32'h7FFFFFFF, 3'b101, 0, 1'b0, 1'b0, 1};
    tbl[8]  = '{32'h80000000, 32'h7FFFFFFF, 3'b110, 0, 1'b0, 1'b0, 1};
    tbl[9]  = '{32'h00000001, 32'h00000002, 3'b011, 1, 1'b0, 1'b1, 1};
    tbl[10] = '{32'h00000080, 32'h00000001, 3'b100, 0, 1'b0, 1'b0, 4};
    tbl[11] = '{32'h01000000, 32'h00FFFFFF, 3'b111, 0, 1'b1, 1'b0, 1};
    tbl[12] = '{32'h00000005, 32'h00000006, 3'b000, 0, 1'b0, 1'b0, 4};
    tbl[13] = '{32'h0000FF00, 32'h00000100, 3'b100, 2, 1'b0, 1'b0, 3};

    rst_n         = 1'b0;
    bus.vin_a     = '0;
    bus.vin_b     = '0;
    bus.func      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {28'd0, bus.in_ready, bus.out_valid, bus.vout, bus.illegal}, 32'b1000);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      run_req(tbl[i].a, tbl[i].b, tbl[i].f, tbl[i].hold, 1'b0, tbl[i].ev, tbl[i].ei, tbl[i].el);
    end

    // Inputs churn and stray requests/acks while busy; only the latched request counts.
    run_req(32'h00000001, 32'h00000002, 3'b100, 2, 1'b1, 1'b1, 1'b0, 4);
    run_req(32'hAB000000, 32'hAC000000, 3'b001, 3, 1'b1, 1'b1, 1'b0, 1);

    // Reset during the second RUN cycle aborts at once.
    bus.vin_a    = 32'hCAFEF00D;
    bus.vin_b    = 32'hCAFEF00D;
    bus.func     = 3'b000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_abort_vld_rdy", {30'd0, bus.out_valid, bus.in_ready}, 32'b01);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 1) @(negedge clk);
    chk("no_output_after_abort", 32'(bus.out_valid), 32'd0);
    run_req(32'h00000005, 32'h00000006, 3'b000, 0, 1'b0, 1'b0, 1'b0, 4);

    for (int r = 0; r < 80; r++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (32'd1 << $urandom_range(0, 31));
        2:       b = {a[31:16], 16'($urandom)};
        default: b = $urandom;
      endcase
      f = 3'($urandom_range(0, 7));
      model(a, b, f, ev, ei, el);
      run_req(a, b, f, $urandom_range(0, 2), 1'b1, ev, ei, el);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
